// File: rtl/mmio_map_pkg.sv
// Address map defaults and field layout shared by the MMIO button bridge.
package mmio_map_pkg;

    localparam logic [31:0] DEF_OUT_ADDR    = 32'd2000;
    localparam logic [31:0] DEF_BTN_BASE    = 32'd3000;
    localparam logic [31:0] DEF_BTN_STRIDE  = 32'd1000;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'd7000;

    // Status word layout: levels from bit 0, sticky flags from bit 16.
    localparam int STAT_LEVEL_LSB  = 0;
    localparam int STAT_STICKY_LSB = 16;

    // Per-channel read word layout.
    localparam int CH_LEVEL_BIT  = 0;
    localparam int CH_STICKY_BIT = 1;

    // Source selected for the registered processor read data.
    typedef enum logic [1:0] {
        SRC_RAM    = 2'd0,
        SRC_OUT    = 2'd1,
        SRC_STATUS = 2'd2,
        SRC_BTN    = 2'd3
    } rd_src_e;

    // Address of button channel idx.
    function automatic logic [31:0] btn_addr(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input int          idx);
        return base + stride * 32'(idx);
    endfunction

endpackage

// File: rtl/mmio_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle rising-edge indication of that level.
module mmio_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int                CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             sync_s;

    assign sync_s = sync_q[1];

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync_s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, counter, level and delayed level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], btn_raw_i};
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
        end
    end

    // Rise is seen in the first cycle the new level is visible on level_o,
    // so a read in that cycle returns the level set but the flag not yet set.
    assign level_o = level_q;
    assign rise_o  = level_q & ~level_dly_q;

endmodule

// File: rtl/mmio_button_bridge.sv
// Memory-mapped bridge: button channels with sticky press flags, the
// processor-to-VGA output register, a status word and the read mux.
module mmio_button_bridge
    import mmio_map_pkg::*;
#(
    parameter int          NUM_BTN         = 4,
    parameter logic [31:0] BTN_BASE        = DEF_BTN_BASE,
    parameter logic [31:0] BTN_STRIDE      = DEF_BTN_STRIDE,
    parameter logic [31:0] OUT_ADDR        = DEF_OUT_ADDR,
    parameter logic [31:0] STATUS_ADDR     = DEF_STATUS_ADDR,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          DATA_W          = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [31:0]        mem_addr,
    input  logic               mem_wren,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [DATA_W-1:0]  proc_rdata,
    output logic [DATA_W-1:0]  vga_data,
    output logic               vga_wr_pulse,
    output logic [NUM_BTN-1:0] btn_level
);

    // True when no two decoded addresses coincide.
    function automatic bit map_ok();
        logic [31:0] a;
        bit          ok;
        ok = (OUT_ADDR != STATUS_ADDR);
        for (int i = 0; i < NUM_BTN; i++) begin
            a = btn_addr(BTN_BASE, BTN_STRIDE, i);
            if (a == OUT_ADDR || a == STATUS_ADDR) ok = 1'b0;
            for (int j = i + 1; j < NUM_BTN; j++) begin
                if (a == btn_addr(BTN_BASE, BTN_STRIDE, j)) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    localparam bit MAP_OK = map_ok();

    if (!MAP_OK) begin : g_bad_map
        $error("mmio_button_bridge: overlapping MMIO addresses");
    end
    if (NUM_BTN < 1 || NUM_BTN > 16) begin : g_bad_num
        $error("mmio_button_bridge: NUM_BTN must be 1..16");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("mmio_button_bridge: DEBOUNCE_CYCLES must be at least 2");
    end
    if (DATA_W < STAT_STICKY_LSB + NUM_BTN) begin : g_bad_w
        $error("mmio_button_bridge: DATA_W too narrow for status word");
    end

    logic [NUM_BTN-1:0] ch_hit;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] sticky_q, sticky_d;
    logic [DATA_W-1:0]  vga_data_q, vga_data_d;
    logic               vga_pulse_q, vga_pulse_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               out_hit, status_hit;
    logic [DATA_W-1:0]  ch_word, status_word;
    rd_src_e            src;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        localparam logic [31:0] CH_ADDR = btn_addr(BTN_BASE, BTN_STRIDE, g);

        assign ch_hit[g] = (mem_addr == CH_ADDR);

        mmio_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clock    (clock),
            .reset    (reset),
            .btn_raw_i(btn_raw[g]),
            .level_o  (level[g]),
            .rise_o   (rise[g])
        );
    end

    assign out_hit    = (mem_addr == OUT_ADDR);
    assign status_hit = (mem_addr == STATUS_ADDR);

    // Sticky flags: a read clears, a same-cycle rising edge overrides the clear.
    always_comb begin
        sticky_d = sticky_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (ch_hit[i] && !mem_wren) sticky_d[i] = 1'b0;
            if (rise[i])                sticky_d[i] = 1'b1;
        end
    end

    // Output register and its write strobe; writes to other mapped addresses are dropped.
    always_comb begin
        vga_data_d  = vga_data_q;
        vga_pulse_d = 1'b0;
        if (mem_wren && out_hit) begin
            vga_data_d  = mem_wdata;
            vga_pulse_d = 1'b1;
        end
    end

    // Read source decode and word assembly from pre-edge state.
    always_comb begin
        ch_word     = '0;
        status_word = '0;
        src         = SRC_RAM;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (ch_hit[i]) begin
                ch_word[CH_LEVEL_BIT]  = level[i];
                ch_word[CH_STICKY_BIT] = sticky_q[i];
            end
        end
        status_word[STAT_LEVEL_LSB  +: NUM_BTN] = level;
        status_word[STAT_STICKY_LSB +: NUM_BTN] = sticky_q;
        if (!mem_wren) begin
            if (out_hit)         src = SRC_OUT;
            else if (status_hit) src = SRC_STATUS;
            else if (|ch_hit)    src = SRC_BTN;
        end
    end

    // Read data mux feeding the registered processor read port.
    always_comb begin
        rdata_d = ram_rdata;
        case (src)
            SRC_OUT:    rdata_d = vga_data_q;
            SRC_STATUS: rdata_d = status_word;
            SRC_BTN:    rdata_d = ch_word;
            default:    rdata_d = ram_rdata;
        endcase
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_q    <= '0;
            vga_data_q  <= '0;
            vga_pulse_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            sticky_q    <= sticky_d;
            vga_data_q  <= vga_data_d;
            vga_pulse_q <= vga_pulse_d;
            rdata_q     <= rdata_d;
        end
    end

    assign proc_rdata   = rdata_q;
    assign vga_data     = vga_data_q;
    assign vga_wr_pulse = vga_pulse_q;
    assign btn_level    = level;

endmodule

// File: tb/tb_mmio_button_bridge.sv
// Self-checking bench for mmio_button_bridge with a short debounce window.
module tb_mmio_button_bridge;

    localparam int NB  = 4;
    localparam int DEB = 4;
    localparam logic [31:0] IDLE = 32'd0;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [31:0]   mem_addr;
    logic          mem_wren;
    logic [31:0]   mem_wdata;
    logic [31:0]   ram_rdata;
    logic [31:0]   proc_rdata;
    logic [31:0]   vga_data;
    logic          vga_wr_pulse;
    logic [NB-1:0] btn_level;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    always #20 clock = ~clock;

    mmio_button_bridge #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DEB),
        .DATA_W         (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .mem_addr    (mem_addr),
        .mem_wren    (mem_wren),
        .mem_wdata   (mem_wdata),
        .ram_rdata   (ram_rdata),
        .proc_rdata  (proc_rdata),
        .vga_data    (vga_data),
        .vga_wr_pulse(vga_wr_pulse),
        .btn_level   (btn_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Read: expectation queued at issue, compared when the registered data appears.
    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        mem_addr = addr;
        mem_wren = 1'b0;
        exp_q.push_back(exp);
        tick();
        chk(tag, proc_rdata, exp_q.pop_front());
        mem_addr = IDLE;
    endtask

    // Write: read port must carry RAM data for the write cycle.
    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        mem_addr  = addr;
        mem_wren  = 1'b1;
        mem_wdata = data;
        exp_q.push_back(ram_rdata);
        tick();
        chk(tag, proc_rdata, exp_q.pop_front());
        mem_wren = 1'b0;
        mem_addr = IDLE;
    endtask

    logic seen_high;

    initial begin
        reset     = 1'b1;
        btn_raw   = 4'hF;
        mem_addr  = IDLE;
        mem_wren  = 1'b0;
        mem_wdata = '0;
        ram_rdata = '0;

        // Reset with buttons held, then 3 edges: nothing may be debounced yet.
        tick();
        chk("rst_vga", vga_data, 32'h0);
        chk("rst_pulse", {31'h0, vga_wr_pulse}, 32'h0);
        chk("rst_rdata", proc_rdata, 32'h0);
        chk("rst_level", {28'h0, btn_level}, 32'h0);
        reset = 1'b0;
        ticks(3);
        chk("rst_level_3", {28'h0, btn_level}, 32'h0);
        chk("rst_outs_3", vga_data | {31'h0, vga_wr_pulse}, 32'h0);

        reset   = 1'b1;
        btn_raw = '0;
        tick();
        reset = 1'b0;
        ticks(2);

        // Press ch1: level appears exactly 2+DEB edges later.
        btn_raw[1] = 1'b1;
        ticks(5);
        chk("deb_edge5", {28'h0, btn_level}, 32'h0);
        tick();
        chk("deb_edge6", {28'h0, btn_level}, 32'h2);

        // A 3-cycle glitch on ch2 must never reach the level.
        btn_raw[2] = 1'b1;
        seen_high  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            seen_high |= btn_level[2];
        end
        btn_raw[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen_high |= btn_level[2];
        end
        chk("glitch", {31'h0, seen_high}, 32'h0);

        // Release ch1 and clear its flag.
        btn_raw[1] = 1'b0;
        ticks(8);
        chk("rel_level", {28'h0, btn_level}, 32'h0);
        rd("ch1_clr", 32'd4000, 32'h2);

        // Sticky read-clear on ch0.
        btn_raw[0] = 1'b1;
        ticks(8);
        btn_raw[0] = 1'b0;
        ticks(8);
        rd("ch0_rd1", 32'd3000, 32'h2);
        rd("ch0_rd2", 32'd3000, 32'h0);

        // Read ch1 in the cycle its level rise becomes visible: set wins over clear.
        btn_raw[1] = 1'b1;
        ticks(6);
        rd("ch1_same", 32'd4000, 32'h1);
        rd("ch1_next", 32'd4000, 32'h3);
        btn_raw[1] = 1'b0;
        ticks(8);

        // Output register, strobe, readback.
        ram_rdata = 32'hCAFE0001;
        wr("wr_rdata", 32'd2000, 32'hDEADBEEF);
        chk("wr_vga", vga_data, 32'hDEADBEEF);
        chk("wr_pulse1", {31'h0, vga_wr_pulse}, 32'h1);
        tick();
        chk("wr_pulse0", {31'h0, vga_wr_pulse}, 32'h0);
        rd("out_rb", 32'd2000, 32'hDEADBEEF);

        // Writes to button/status addresses change nothing.
        wr("wr_btn_rdata", 32'd3000, 32'h5);
        chk("wr_btn_pulse", {31'h0, vga_wr_pulse}, 32'h0);
        wr("wr_stat_rdata", 32'd7000, 32'hFFFF_FFFF);
        chk("wr_btn_vga", vga_data, 32'hDEADBEEF);
        rd("wr_btn_ch0", 32'd3000, 32'h0);
        rd("wr_btn_stat", 32'd7000, 32'h0);

        // Back-to-back writes strobe every cycle.
        mem_addr  = 32'd2000;
        mem_wren  = 1'b1;
        mem_wdata = 32'h1;
        tick();
        chk("b2b_p1", {31'h0, vga_wr_pulse}, 32'h1);
        mem_wdata = 32'h2;
        tick();
        chk("b2b_p2", {31'h0, vga_wr_pulse}, 32'h1);
        chk("b2b_vga", vga_data, 32'h2);
        mem_wren = 1'b0;
        mem_addr = IDLE;
        tick();
        chk("b2b_p3", {31'h0, vga_wr_pulse}, 32'h0);

        // Status word with ch0 and ch3 pressed; status read does not clear.
        btn_raw = 4'b1001;
        ticks(8);
        rd("status1", 32'd7000, 32'h0009_0009);
        rd("status2", 32'd7000, 32'h0009_0009);
        rd("ch3_rd", 32'd6000, 32'h3);
        rd("status3", 32'd7000, 32'h0001_0009);

        // RAM passthrough.
        ram_rdata = 32'h1234;
        rd("ram_pass", 32'd100, 32'h1234);

        // Reset mid-debounce discards everything.
        btn_raw[2] = 1'b1;
        ticks(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_level", {28'h0, btn_level}, 32'h0);
        chk("mid_rst_vga", vga_data, 32'h0);
        ticks(5);
        chk("mid_rst_edge5", {28'h0, btn_level}, 32'h0);
        tick();
        chk("mid_rst_edge6", {28'h0, btn_level}, 32'hD);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmio_button_bridge.md
Name: mmio_button_bridge

Overview:
- Parametrised memory-mapped I/O bridge between the processor data-memory port, NUM_BTN push-buttons, RAM read data and the VGA controller.
- Per channel: 2-flop synchroniser, counter debouncer, and a sticky press flag cleared on read.
- Output register with a write strobe; status word; registered read mux back to the processor.
- Replaces the hand-coded fixed-address button/output decoding in the top level.

Parameters:
- NUM_BTN, 4, number of button channels (1..16).
- BTN_BASE, 3000, address of button channel 0.
- BTN_STRIDE, 1000, address step between channels; channel i at BTN_BASE + i*BTN_STRIDE.
- OUT_ADDR, 2000, address of the processor-to-VGA output register.
- STATUS_ADDR, 7000, address of the read-only aggregate status word.
- DEBOUNCE_CYCLES, 250000, stable clock cycles required before a level change is accepted (10 ms at 25 MHz; minimum 2).
- DATA_W, 32, data width.

Ports:
- clock  in  1  system clock (25 MHz domain).
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  NUM_BTN  asynchronous raw button inputs.
- mem_addr  in  32  processor data address.
- mem_wren  in  1  processor data write enable.
- mem_wdata  in  DATA_W  processor write data.
- ram_rdata  in  DATA_W  RAM read data for non-I/O addresses.
- proc_rdata  out  DATA_W  registered read data to processor.
- vga_data  out  DATA_W  last value written to OUT_ADDR.
- vga_wr_pulse  out  1  one-cycle strobe on each OUT_ADDR write.
- btn_level  out  NUM_BTN  debounced button levels.

Behaviour:
- Reset (synchronous, one clock edge with reset=1) clears all of the following to 0:
  - synchroniser flops, debounce counters, btn_level and sticky flags;
  - vga_data, vga_wr_pulse and proc_rdata.
- Reset asserted mid-debounce or mid-access discards all in-progress state. There is no partial update.
- Synchroniser: per channel, 2 flops; sync_i lags btn_raw by 2 edges.
- Debounce, per channel:
  - sync_i == btn_level[i]: counter <= 0.
  - Otherwise counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while still differing: btn_level[i] <= sync_i and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
  - Total press latency: 2 + DEBOUNCE_CYCLES edges.
- Sticky flag, per channel: set on a btn_level rising edge (0->1). Cleared by a read of that channel's address (mem_wren=0).
  - Rising edge and clearing read in the same cycle: the set wins, flag = 1 afterwards. That read returns the pre-edge value.
- Address decode:
  - Exact 32-bit compare.
  - Channel match: mem_addr == BTN_BASE + i*BTN_STRIDE, computed at elaboration.
  - Overlapping addresses are a parameter error, checked by an elaboration assertion.
- Reads (mem_wren=0): proc_rdata registered, 1-cycle latency, from the current-cycle address:
  - Channel i: {zeros, sticky[i], btn_level[i]} (bit1 sticky, bit0 level).
  - STATUS_ADDR: bits[NUM_BTN-1:0] = btn_level; bits[16+NUM_BTN-1:16] = sticky; other bits 0. Does not clear flags.
  - OUT_ADDR: vga_data (readback).
  - Any other address: ram_rdata.
- Writes (mem_wren=1):
  - OUT_ADDR: vga_data <= mem_wdata; vga_wr_pulse = 1 for exactly the next cycle. Back-to-back writes give a pulse every cycle.
  - Button and status addresses: the write is ignored and no state changes.
  - Other addresses: no effect in this block (RAM handles them).
  - proc_rdata during a write cycle: ram_rdata.
- vga_data holds its value until the next OUT_ADDR write or reset.

Decomposition:
- Package mmio_map_pkg: default address constants (OUT_ADDR 2000, BTN_BASE 3000, BTN_STRIDE 1000, STATUS_ADDR 7000), status bit-field offsets (level at 0, sticky at 16), and the channel read bit positions.
- Sub-module mmio_debounce_ch: synchroniser, counter, level and rising-edge output for one channel. Instantiated NUM_BTN times via generate.
- Top level: decode, sticky flags, output register, read mux.

Test Plan:
All tests use DEBOUNCE_CYCLES=4 and NUM_BTN=4.
1. Reset: assert reset for 1 edge with btn_raw=4'hF, then release and hold for 3 edges -> all outputs 0; btn_level still 0 after those 3 edges.
2. Debounce: btn_raw[1]=1 held -> btn_level = 4'b0010 exactly 6 edges after the change.
   - A 3-cycle pulse on btn_raw[2] -> btn_level[2] never rises.
3. Sticky read-clear: press and release ch0 (level rises, then falls).
   - Read addr 3000 -> proc_rdata = 32'h2 one cycle later.
   - Second read of 3000 -> 32'h0.
4. Simultaneous set and clear: read addr 4000 in the same cycle btn_level[1] rises -> proc_rdata = 32'h1; next read of 4000 -> 32'h3.
5. Output: write 32'hDEADBEEF to 2000 -> vga_data = DEADBEEF and vga_wr_pulse high for exactly 1 cycle; read 2000 -> DEADBEEF.
   - Write 5 to 3000 -> no state change.
6. Status and passthrough: ch0 and ch3 held pressed with both sticky flags set -> read 7000 returns 32'h0009_0009 and the flags are not cleared.
   - Read addr 100 with ram_rdata=32'h1234 -> proc_rdata = 32'h1234 after 1 cycle.
